mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the memory port arbiter.
// The arbiter connects through the slave modport; requesters and memory use master.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_ready;
  logic [63:0] d_rdata;

  logic        err;

  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_ready, if_rdata, d_ready, d_rdata, err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_ready, if_rdata, d_ready, d_rdata, err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data is favoured, but fetch is guaranteed a grant after MAX_D_STREAK data grants.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 2,
  parameter int unsigned TIMEOUT      = 15
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [3:0]    WAIT_LAST  = 4'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_e;

  state_e        state_q,     state_d;
  logic [SW-1:0] streak_q,    streak_d;
  logic [3:0]    wait_q,      wait_d;
  logic          if_ready_q,  if_ready_d;
  logic [31:0]   if_rdata_q,  if_rdata_d;
  logic          d_ready_q,   d_ready_d;
  logic [63:0]   d_rdata_q,   d_rdata_d;
  logic          err_q,       err_d;
  logic          mem_req_q,   mem_req_d;
  logic          mem_we_q,    mem_we_d;
  logic [63:0]   mem_addr_q,  mem_addr_d;
  logic [63:0]   mem_wdata_q, mem_wdata_d;

  logic grant_if;
  logic grant_d;

  // Fetch wins only when data is absent or data has used up its streak.
  assign grant_if = bus.if_req && (!bus.d_req || (streak_q == STREAK_MAX));
  assign grant_d  = bus.d_req && !grant_if;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    wait_d      = wait_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (!bus.if_req) begin
          streak_d = '0;
        end
        if (grant_if) begin
          state_d     = BUSY_IF;
          streak_d    = '0;
          wait_d      = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = '0;
        end else if (grant_d) begin
          state_d     = BUSY_D;
          wait_d      = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.d_we;
          mem_addr_d  = bus.d_addr;
          mem_wdata_d = bus.d_wdata;
          if (bus.if_req && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + SW'(1);
          end
        end
      end

      BUSY_IF, BUSY_D: begin
        if (bus.mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = bus.mem_rdata[31:0];
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = mem_we_q ? 64'd0 : bus.mem_rdata;
          end
        end else if (wait_q == WAIT_LAST) begin
          // This cycle would bring the count to TIMEOUT: give up with err.
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == BUSY_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = '0;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      wait_q      <= '0;
      if_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_ready_q   <= 1'b0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      wait_q      <= wait_d;
      if_ready_q  <= if_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_ready_q   <= d_ready_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboard of expected ready pulses
// plus per-scenario tasks for timing, arbitration order, timeout and reset.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_D_STREAK(2), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  exp_t  if_exp[$];
  exp_t  d_exp[$];
  string order_s = "";

  int ack_delay = 0;
  bit ack_en    = 1'b1;
  bit force_ack = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<300000", $time);
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    if (a == 64'h40) return 64'hCAFE_F00D_0050_0093;
    return {~a[31:0], a[31:0] ^ 32'h1357_9BDF};
  endfunction

  // Memory: acks ack_delay cycles after mem_req rises, junk data otherwise.
  initial begin
    int age;
    age = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (force_ack || (bus.mem_req && ack_en && age == ack_delay)) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = force_ack ? {$urandom, $urandom} : mem_model(bus.mem_addr);
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = {$urandom, $urandom};
      end
      if (bus.mem_req) age++;
      else age = 0;
    end
  end

  // Scoreboard: every ready pulse must match the oldest expectation for that port.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.if_ready === 1'b1) begin
      order_s = {order_s, "I"};
      checks++;
      if (if_exp.size() == 0) begin
        errors++;
        $display("FAIL if_unexpected: if_ready pulsed at cycle %0d, required no pulse", cyc);
      end else begin
        e = if_exp.pop_front();
        if ({bus.if_rdata, bus.err} !== {e.rdata[31:0], e.err}) begin
          errors++;
          $display("FAIL if_result: rdata=%h err=%b required rdata=%h err=%b",
                   bus.if_rdata, bus.err, e.rdata[31:0], e.err);
        end
      end
    end
    if (bus.d_ready === 1'b1) begin
      order_s = {order_s, "D"};
      checks++;
      if (d_exp.size() == 0) begin
        errors++;
        $display("FAIL d_unexpected: d_ready pulsed at cycle %0d, required no pulse", cyc);
      end else begin
        e = d_exp.pop_front();
        if ({bus.d_rdata, bus.err} !== {e.rdata, e.err}) begin
          errors++;
          $display("FAIL d_result: rdata=%h err=%b required rdata=%h err=%b",
                   bus.d_rdata, bus.err, e.rdata, e.err);
        end
      end
    end
  end

  task automatic fetch_txn(input logic [63:0] addr);
    exp_t e;
    logic [63:0] m;
    m = mem_model(addr);
    e.rdata = {32'h0, m[31:0]};
    e.err   = 1'b0;
    if_exp.push_back(e);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (bus.if_ready === 1'b1) break;
    end
    bus.if_req = 1'b0;
  endtask

  task automatic data_txn(input logic [63:0] addr, input logic we, input logic [63:0] wdata,
                          input logic exp_err);
    exp_t e;
    e.rdata = (we || exp_err) ? 64'd0 : mem_model(addr);
    e.err   = exp_err;
    d_exp.push_back(e);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (bus.d_ready === 1'b1) break;
    end
    bus.d_req = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.d_req  = 1'b1;
    bus.d_addr = 64'h55;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_ready, bus.d_ready,
         bus.err, bus.if_rdata, bus.d_rdata} !== 229'd0) begin
      errors++;
      $display("FAIL reset_state: mem_req=%b mem_addr=%h if_ready=%b d_ready=%b err=%b required all 0",
               bus.mem_req, bus.mem_addr, bus.if_ready, bus.d_ready, bus.err);
    end
    bus.d_req = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fetch();
    exp_t e;
    int pulses = 0;
    int seen   = 0;
    bit bad    = 1'b0;
    ack_delay = 1;
    e.rdata = 64'h0000_0000_0050_0093;
    e.err   = 1'b0;
    if_exp.push_back(e);
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h40;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req === 1'b1) begin
        seen++;
        if (bus.mem_addr !== 64'h40 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 64'h0) bad = 1'b1;
      end
      if (bus.if_ready === 1'b1) begin
        pulses++;
        bus.if_req = 1'b0;
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL fetch_bus: mem_addr/mem_we/mem_wdata wrong, required 40/0/0");
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL fetch_pulses: if_ready pulses=%0d required 1", pulses);
    end
    checks++;
    if (seen != 2) begin
      errors++;
      $display("FAIL fetch_req_cycles: mem_req cycles=%0d required 2", seen);
    end
    ack_delay = 0;
  endtask

  task automatic test_latency();
    int c0;
    int t_req = -1;
    int t_rdy = -1;
    exp_t e;
    e.rdata = mem_model(64'h200);
    e.err   = 1'b0;
    d_exp.push_back(e);
    ack_delay  = 0;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 64'h200;
    c0 = cyc;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req === 1'b1 && t_req < 0) t_req = cyc;
      if (bus.d_ready === 1'b1) begin
        t_rdy = cyc;
        bus.d_req = 1'b0;
        break;
      end
    end
    checks++;
    if (t_req - c0 != 1 || t_rdy - c0 != 2) begin
      errors++;
      $display("FAIL latency: mem_req after %0d ready after %0d cycles, required 1 and 2",
               t_req - c0, t_rdy - c0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_store();
    exp_t e;
    int pulses = 0;
    int seen   = 0;
    bit bad    = 1'b0;
    ack_delay = 3;
    e.rdata = 64'd0;
    e.err   = 1'b0;
    d_exp.push_back(e);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 64'h100;
    bus.d_wdata = 64'hDEADBEEF;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req === 1'b1) begin
        seen++;
        if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 64'hDEADBEEF || bus.mem_addr !== 64'h100)
          bad = 1'b1;
      end
      if (bus.d_ready === 1'b1) begin
        pulses++;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
      end
    end
    checks++;
    if (bad || seen != 4) begin
      errors++;
      $display("FAIL store_bus: bad=%0d mem_req cycles=%0d required bad=0 cycles=4", bad, seen);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL store_pulses: d_ready pulses=%0d required 1", pulses);
    end
    ack_delay = 0;
  endtask

  task automatic test_arbitration();
    ack_delay = 0;
    order_s   = "";
    fork
      begin
        for (int i = 0; i < 2; i++) fetch_txn(64'h80 + 64'(i * 4));
      end
      begin
        for (int i = 0; i < 4; i++) data_txn(64'h100 + 64'(i * 8), 1'b0, 64'd0, 1'b0);
      end
    join
    checks++;
    if (order_s != "DDIDDI") begin
      errors++;
      $display("FAIL grant_order: order=%s required DDIDDI", order_s);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ack_idle();
    logic [63:0] mi;
    logic [63:0] md;
    int pulses = 0;
    mi = mem_model(64'h84);
    md = mem_model(64'h118);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    force_ack = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.if_ready === 1'b1 || bus.d_ready === 1'b1 || bus.mem_req === 1'b1) pulses++;
    end
    force_ack = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (bus.if_ready === 1'b1 || bus.d_ready === 1'b1 || bus.mem_req === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL ack_in_idle: activity cycles=%0d required 0", pulses);
    end
    checks++;
    if (bus.if_rdata !== mi[31:0] || bus.d_rdata !== md) begin
      errors++;
      $display("FAIL rdata_hold: if_rdata=%h d_rdata=%h required %h %h",
               bus.if_rdata, bus.d_rdata, mi[31:0], md);
    end
  endtask

  task automatic test_drop_req();
    exp_t e;
    int pulses = 0;
    ack_delay = 3;
    e.rdata = mem_model(64'h240);
    e.err   = 1'b0;
    d_exp.push_back(e);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 64'h240;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req === 1'b1) bus.d_req = 1'b0;
      if (bus.d_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL drop_req: d_ready pulses=%0d required 1", pulses);
    end
    ack_delay = 0;
  endtask

  task automatic test_timeout();
    exp_t e;
    int t_rise = -1;
    int t_rdy  = -1;
    logic err_seen = 1'b0;
    logic req_at   = 1'b1;
    logic req_next = 1'b1;
    ack_en  = 1'b0;
    e.rdata = 64'd0;
    e.err   = 1'b1;
    d_exp.push_back(e);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 64'h300;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req === 1'b1 && t_rise < 0) t_rise = cyc;
      if (bus.d_ready === 1'b1) begin
        t_rdy    = cyc;
        err_seen = bus.err;
        req_at   = bus.mem_req;
        bus.d_req = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_next = bus.mem_req;
    ack_en   = 1'b1;
    checks++;
    if (t_rise < 0 || t_rdy - t_rise != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_latency: ready %0d cycles after mem_req rose, required %0d",
               t_rdy - t_rise, TIMEOUT);
    end
    checks++;
    if (err_seen !== 1'b1 || req_at !== 1'b0 || req_next !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flags: err=%b mem_req=%b,%b required err=1 mem_req=0,0",
               err_seen, req_at, req_next);
    end
    // mem_ack landing on the timeout cycle must still count as success.
    ack_delay = TIMEOUT - 1;
    data_txn(64'h308, 1'b0, 64'd0, 1'b0);
    ack_delay = TIMEOUT;
    data_txn(64'h310, 1'b0, 64'd0, 1'b1);
    ack_delay = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int pulses = 0;
    bit granted = 1'b0;
    ack_en     = 1'b0;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 64'h400;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req === 1'b1) break;
    end
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h500;
    @(posedge clk);
    #1;
    reset     = 1'b1;
    bus.d_req = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_ready, bus.d_ready,
         bus.err, bus.if_rdata, bus.d_rdata} !== 229'd0) begin
      errors++;
      $display("FAIL reset_mid_state: mem_req=%b mem_addr=%h d_ready=%b d_rdata=%h required all 0",
               bus.mem_req, bus.mem_addr, bus.d_ready, bus.d_rdata);
    end
    ack_en = 1'b1;
    e.rdata = {32'h0, 32'h0} | {32'h0, mem_model(64'h500) & 64'hFFFF_FFFF};
    e.err   = 1'b0;
    if_exp.push_back(e);
    reset = 1'b0;
    @(posedge clk);
    #1;
    granted = (bus.mem_req === 1'b1 && bus.mem_addr === 64'h500 && bus.mem_we === 1'b0);
    checks++;
    if (!granted) begin
      errors++;
      $display("FAIL reset_regrant: mem_req=%b mem_addr=%h required 1 and 500",
               bus.mem_req, bus.mem_addr);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.if_ready === 1'b1) begin
        pulses++;
        bus.if_req = 1'b0;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL reset_fetch_done: if_ready pulses=%0d required 1", pulses);
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    test_reset();
    test_fetch();
    test_latency();
    test_store();
    test_arbitration();
    test_ack_idle();
    test_drop_req();
    test_timeout();
    test_reset_mid();

    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (if_exp.size() != 0 || d_exp.size() != 0) begin
      errors++;
      $display("FAIL missing_ready: outstanding if=%0d d=%0d required 0 0",
               if_exp.size(), d_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
